// File: rtl/fifo_byte_drain_pkg.sv
// Shared definitions for the FIFO byte-drain stage.
// Contents:
//   drain_state_t  - FSM state encoding (IDLE, REQ, LATCH, SEND)
//   BYTES_PER_WORD - bytes serialised per popped FIFO word
//   FIFO_DATA_W    - width of the upstream FIFO read data
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } drain_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int FIFO_DATA_W    = 32;

endpackage

// File: rtl/fifo_byte_drain.sv
// Pops 32-bit words from a synchronous FIFO and serialises each one as four
// bytes on a byte-wide valid/ready stream, flagging frame ends with m_last.
//
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   fifo_data    - FIFO read data, valid the cycle after a fifo_rd_en pulse
//   fifo_empty   - registered FIFO empty flag (lags occupancy by one cycle)
//   fifo_rd_en   - single-cycle pop request
//   m_data       - output byte
//   m_valid      - m_data is valid; held until m_ready
//   m_ready      - downstream accepts the byte
//   m_last       - final byte of a frame
//   words_sent   - wrapping count of fully transmitted words
//   busy         - FSM is not in IDLE
//
// State table:
//   IDLE  | waiting for a non-empty FIFO
//   REQ   | fifo_rd_en asserted for this one cycle
//   LATCH | FIFO read data captured into the shift register
//   SEND  | four bytes handed out under valid/ready
module fifo_byte_drain
  import fifo_pkg::*;
#(
  parameter bit MSB_FIRST       = 1'b1,
  parameter int WORDS_PER_FRAME = 4,
  parameter int CNT_W           = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FIFO_DATA_W-1:0] fifo_data,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [7:0]             m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [CNT_W-1:0]       words_sent,
  output logic                   busy
);

  localparam int                 FRAME_W      = 16;
  localparam logic [FRAME_W-1:0] LAST_FRAME   = FRAME_W'(WORDS_PER_FRAME - 1);
  localparam logic [1:0]         LAST_BYTE    = 2'(BYTES_PER_WORD - 1);
  localparam logic [1:0]         PRELAST_BYTE = 2'(BYTES_PER_WORD - 2);

  drain_state_t           state_q;
  logic [FIFO_DATA_W-1:0] shift_q, shift_d;
  logic [1:0]             byte_idx_q;
  logic [FRAME_W-1:0]     frame_idx_q, frame_idx_d;
  logic [CNT_W-1:0]       words_q;
  logic                   rd_en_q, valid_q, last_q, busy_q;
  logic                   xfer;

  assign xfer = valid_q && m_ready;

  // The shift always moves the next byte into the output position, so m_data
  // is a fixed slice of the register and needs no byte-index mux.
  always_comb begin
    shift_d     = MSB_FIRST ? {shift_q[FIFO_DATA_W-9:0], 8'h00}
                            : {8'h00, shift_q[FIFO_DATA_W-1:8]};
    frame_idx_d = (frame_idx_q == LAST_FRAME) ? '0 : frame_idx_q + FRAME_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      frame_idx_q <= '0;
      words_q     <= '0;
      rd_en_q     <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= REQ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          state_q <= LATCH;
          rd_en_q <= 1'b0;
        end
        LATCH: begin
          shift_q    <= fifo_data;
          byte_idx_q <= '0;
          valid_q    <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (xfer) begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            // m_last is raised as the third byte leaves so it sits with the fourth.
            last_q     <= (byte_idx_q == PRELAST_BYTE) && (frame_idx_q == LAST_FRAME);
            if (byte_idx_q == LAST_BYTE) begin
              valid_q     <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
              words_q     <= words_q + CNT_W'(1);
              frame_idx_q <= frame_idx_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign m_valid    = valid_q;
  assign m_last     = last_q;
  assign busy       = busy_q;
  assign words_sent = words_q;
  assign m_data     = MSB_FIRST ? shift_q[FIFO_DATA_W-1:FIFO_DATA_W-8] : shift_q[7:0];

endmodule
